// File: rtl/axis_burst_gate_pkg.sv
// Shared types and helpers for the AXI-stream burst gate.
// Both the gate and its idle timer import this package.
package axis_burst_gate_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Maximum number of beats in one packet: MAXB = 2^lgburst.
  function automatic int unsigned burst_max(input int unsigned lgburst);
    return 32'd1 << lgburst;
  endfunction

  // Idle timeout in cycles: TMO = 2^lgtimeout - 1.
  function automatic int unsigned timeout_max(input int unsigned lgtimeout);
    return (32'd1 << lgtimeout) - 32'd1;
  endfunction

endpackage

// File: rtl/axis_burst_timer.sv
// Saturating idle counter for axis_burst_gate.
// Clear has priority over enable; o_tc is high while the count sits at TMO.
module axis_burst_timer
  import axis_burst_gate_pkg::*;
#(
  parameter int LGTIMEOUT = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [LGTIMEOUT-1:0] TMO = LGTIMEOUT'(timeout_max(LGTIMEOUT));

  logic [LGTIMEOUT-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tc = (r_count == TMO);

endmodule

// File: rtl/axis_burst_gate.sv
// Holds FIFO data until a full burst or an idle timeout, then drains it as one
// TLAST-delimited AXI-stream packet. Optional counters: AXIS_BURST_GATE_STATS_EN.
module axis_burst_gate
  import axis_burst_gate_pkg::*;
#(
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int LGBURST   = 3,
  parameter int LGTIMEOUT = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_rd,
  input  logic [BW-1:0]     i_data,
  input  logic              i_empty,
  input  logic [LGFLEN:0]   i_fill,
  input  logic              i_flush,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic [BW-1:0]     M_AXIS_TDATA,
  output logic              M_AXIS_TLAST,
  output logic              o_busy
`ifdef AXIS_BURST_GATE_STATS_EN
  ,
  output logic [31:0]       o_nbursts,
  output logic [31:0]       o_nshort
`endif
);

  localparam int              MAXB      = burst_max(LGBURST);
  localparam logic [LGBURST:0] MAXB_LEN  = (LGBURST+1)'(MAXB);
  localparam logic [LGFLEN:0]  MAXB_FILL = (LGFLEN+1)'(MAXB);

  state_t               r_state;
  logic [LGBURST:0]     r_len;
  logic [LGBURST-1:0]   r_beat;

  logic fill_nz;
  logic fill_full;
  logic tmr_tc;
  logic tmr_clear;
  logic tmr_en;
  logic start;
  logic last_beat;

  assign fill_nz   = (i_fill != '0);
  assign fill_full = (i_fill >= MAXB_FILL);
  assign start     = (r_state == IDLE) && fill_nz && (fill_full || tmr_tc || i_flush);

  // The timer only ages a partial, non-empty FIFO while idle.
  assign tmr_en    = (r_state == IDLE);
  assign tmr_clear = (r_state == BURST) || start || !fill_nz || fill_full;

  axis_burst_timer #(
    .LGTIMEOUT(LGTIMEOUT)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (tmr_clear),
    .i_en    (tmr_en),
    .o_tc    (tmr_tc)
  );

  assign last_beat     = ({1'b0, r_beat} == (r_len - 1'b1));
  assign o_busy        = (r_state == BURST);
  assign M_AXIS_TVALID = o_busy && !i_empty;
  assign M_AXIS_TLAST  = o_busy && last_beat;
  assign M_AXIS_TDATA  = i_data;
  assign o_rd          = M_AXIS_TVALID && M_AXIS_TREADY;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_beat  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state <= BURST;
            r_len   <= fill_full ? MAXB_LEN : i_fill[LGBURST:0];
            r_beat  <= '0;
          end
        end
        BURST: begin
          if (o_rd) begin
            if (last_beat) begin
              r_state <= IDLE;
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AXIS_BURST_GATE_STATS_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_nbursts <= '0;
      o_nshort  <= '0;
    end else if (o_rd && M_AXIS_TLAST) begin
      o_nbursts <= o_nbursts + 32'd1;
      if (r_len < MAXB_LEN) begin
        o_nshort <= o_nshort + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_axis_burst_gate.sv
// Bench for axis_burst_gate: a queue-based FIFO model, a packet-level reference
// model, scenario tables, hand-written reset sequences and randomized traffic.
module tb_axis_burst_gate;

  localparam int BW        = 8;
  localparam int LGFLEN    = 4;
  localparam int LGBURST   = 3;
  localparam int LGTIMEOUT = 4;
  localparam int MAXB      = 1 << LGBURST;
  localparam int TMO       = (1 << LGTIMEOUT) - 1;
  localparam int DEPTH     = 1 << LGFLEN;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              o_rd;
  logic [BW-1:0]     i_data = '0;
  logic              i_empty = 1'b1;
  logic [LGFLEN:0]   i_fill = '0;
  logic              i_flush = 1'b0;
  logic              M_AXIS_TVALID;
  logic              M_AXIS_TREADY = 1'b0;
  logic [BW-1:0]     M_AXIS_TDATA;
  logic              M_AXIS_TLAST;
  logic              o_busy;
`ifdef AXIS_BURST_GATE_STATS_EN
  logic [31:0]       o_nbursts;
  logic [31:0]       o_nshort;
`endif

  axis_burst_gate #(
    .BW(BW), .LGFLEN(LGFLEN), .LGBURST(LGBURST), .LGTIMEOUT(LGTIMEOUT)
  ) dut (
    .i_clk         (i_clk),
    .i_reset       (i_reset),
    .o_rd          (o_rd),
    .i_data        (i_data),
    .i_empty       (i_empty),
    .i_fill        (i_fill),
    .i_flush       (i_flush),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .o_busy        (o_busy)
`ifdef AXIS_BURST_GATE_STATS_EN
    ,
    .o_nbursts     (o_nbursts),
    .o_nshort      (o_nshort)
`endif
  );

  always #5 i_clk = ~i_clk;

  // Environment FIFO, data-order scoreboard and packet monitor
  logic [BW-1:0] fifo_q[$];
  logic [BW-1:0] exp_q[$];
  int            got_lens[$];
  int            beat_cnt = 0;
  int            cyc = 0;

  // Packet-level reference: remaining beats of the current packet, age of
  // the oldest waiting data while idle.
  bit m_busy = 0;
  int m_left = 0;
  int m_len  = 0;
  int m_age  = 0;
  int m_nbursts = 0;
  int m_nshort  = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_fifo();
    i_fill  = (LGFLEN+1)'(fifo_q.size());
    i_empty = (fifo_q.size() == 0);
    i_data  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic cycle(input bit wr, input logic [BW-1:0] wd, input bit rdy,
                       input bit fl, input bit rst);
    bit e_valid, e_last, e_rd, saw_rd, saw_last;
    int fill;
    i_reset = rst;
    M_AXIS_TREADY = rdy;
    i_flush = fl;
    drive_fifo();
    @(negedge i_clk);
    fill    = fifo_q.size();
    e_valid = m_busy && (fill != 0);
    e_last  = m_busy && (m_left == 1);
    e_rd    = e_valid && rdy;
    check("tvalid", 32'(M_AXIS_TVALID), 32'(e_valid));
    check("tlast",  32'(M_AXIS_TLAST),  32'(e_last));
    check("o_rd",   32'(o_rd),          32'(e_rd));
    check("o_busy", 32'(o_busy),        32'(m_busy));
    if (e_valid) check("tdata", 32'(M_AXIS_TDATA), 32'(fifo_q[0]));
`ifdef AXIS_BURST_GATE_STATS_EN
    check("nbursts", o_nbursts, 32'(m_nbursts));
    check("nshort",  o_nshort,  32'(m_nshort));
`endif
    saw_rd   = o_rd;
    saw_last = M_AXIS_TLAST;
    if (saw_rd) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL order @cyc %0d: read with no data written", cyc);
      end else begin
        check("order", 32'(M_AXIS_TDATA), 32'(exp_q.pop_front()));
      end
      beat_cnt++;
      if (saw_last) begin
        got_lens.push_back(beat_cnt);
        beat_cnt = 0;
      end
    end
    @(posedge i_clk);
    if (rst) begin
      m_busy = 0; m_left = 0; m_len = 0; m_age = 0;
      m_nbursts = 0; m_nshort = 0;
      fifo_q.delete();
      exp_q.delete();
      beat_cnt = 0;
    end else begin
      if (m_busy) begin
        if (e_rd) begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 0;
            m_nbursts++;
            if (m_len < MAXB) m_nshort++;
          end
        end
      end else if (fill != 0 && (fill >= MAXB || m_age >= TMO || fl)) begin
        m_busy = 1;
        m_len  = (fill < MAXB) ? fill : MAXB;
        m_left = m_len;
        m_age  = 0;
      end else if (fill == 0 || fill >= MAXB) begin
        m_age = 0;
      end else if (m_age < TMO) begin
        m_age++;
      end
      if (saw_rd) void'(fifo_q.pop_front());
      if (wr) begin
        fifo_q.push_back(wd);
        exp_q.push_back(wd);
      end
    end
    cyc++;
    #1;
  endtask

  typedef struct {
    int nwr;
    bit toggle;
    bit flush;
    int npk;
    int len[3];
  } vec_t;

  function automatic vec_t mk(input int nwr, input bit tog, input bit fl,
                              input int n, input int l0, input int l1, input int l2);
    vec_t v;
    v.nwr = nwr; v.toggle = tog; v.flush = fl; v.npk = n;
    v.len[0] = l0; v.len[1] = l1; v.len[2] = l2;
    return v;
  endfunction

  vec_t tbl[5];

  initial begin
    bit rdy;
    bit reached;

    tbl[0] = mk(8,  0, 0, 1, 8, 0, 0);   // full burst
    tbl[1] = mk(3,  0, 0, 1, 3, 0, 0);   // short burst after timeout
    tbl[2] = mk(20, 0, 0, 3, 8, 8, 4);   // streaming, tail waits for timeout
    tbl[3] = mk(8,  1, 0, 1, 8, 0, 0);   // TREADY toggling 1,0
    tbl[4] = mk(2,  0, 1, 1, 2, 0, 0);   // flush drains early

    // Reset state
    for (int i = 0; i < 3; i++) cycle(0, '0, 1'b1, 1'b0, 1'b1);
    check("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("rst_busy",   32'(o_busy),        32'd0);
    check("rst_rd",     32'(o_rd),          32'd0);

    foreach (tbl[r]) begin
      got_lens.delete();
      for (int i = 0; i < tbl[r].nwr; i++) begin
        rdy = tbl[r].toggle ? (cyc % 2 == 0) : 1'b1;
        cycle(1'b1, BW'($urandom_range(0, 255)), rdy, 1'b0, 1'b0);
      end
      for (int i = 0; i < 45; i++) begin
        rdy = tbl[r].toggle ? (cyc % 2 == 0) : 1'b1;
        cycle(1'b0, '0, rdy, (i == 0) && tbl[r].flush, 1'b0);
      end
      check($sformatf("row%0d_npkts", r), 32'(got_lens.size()), 32'(tbl[r].npk));
      for (int k = 0; k < tbl[r].npk; k++) begin
        if (k < got_lens.size())
          check($sformatf("row%0d_len%0d", r, k), 32'(got_lens[k]), 32'(tbl[r].len[k]));
      end
      check($sformatf("row%0d_drained", r), 32'(fifo_q.size()), 32'd0);
    end

    // Flush with an empty FIFO does nothing
    cycle(1'b0, '0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_empty_busy", 32'(o_busy), 32'd0);

    // Reset after beat 4 of an 8-beat burst
    for (int i = 0; i < 8; i++) cycle(1'b1, BW'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
    reached = 0;
    for (int i = 0; i < 30 && !reached; i++) begin
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
      if (beat_cnt >= 4) reached = 1;
    end
    if (!reached) begin
      n_cmp++;
      n_bad++;
      $display("FAIL midrst_wait: got %0d beats required 4", beat_cnt);
    end
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
    drive_fifo();
    check("midrst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
    check("midrst_busy",   32'(o_busy),        32'd0);
`ifdef AXIS_BURST_GATE_STATS_EN
    check("midrst_nbursts", o_nbursts, 32'd0);
    check("midrst_nshort",  o_nshort,  32'd0);
`endif
    for (int i = 0; i < 20; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized traffic with varying write density
    for (int i = 0; i < 900; i++) begin
      int dens;
      bit wr;
      dens = (i / 150) % 3;
      wr = (fifo_q.size() < DEPTH) && ($urandom_range(0, 7) < (dens == 0 ? 1 : dens == 1 ? 4 : 7));
      cycle(wr, BW'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0), 1'b0);
    end
    for (int i = 0; i < 60; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    check("rand_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
